// File: rtl/xmint_arb_pkg.sv
// Shared types and constants for the xmint two-to-one memory port arbiter.
// Optional build macro: XMINT_ARB_RR_EN (round-robin instead of fixed data priority).
package xmint_arb_pkg;

  typedef enum logic {
    ARB_ID_INSTR = 1'b0,
    ARB_ID_DATA  = 1'b1
  } arb_id_e;

  typedef enum logic {
    LOCK_IDLE = 1'b0,
    LOCK_HELD = 1'b1
  } lock_state_e;

  // Wide enough for any practical DATA_WIDTH/8; the top slices what it needs.
  localparam logic [127:0] ARB_BE_ALL = {128{1'b1}};

endpackage

// File: rtl/xmint_arb_id_fifo.sv
// In-order FIFO of 1-bit requester IDs for granted-but-unanswered transactions.
// A pop frees its slot in the same cycle, so push and pop may coincide when full.
module xmint_arb_id_fifo
  import xmint_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  input  logic    push_i,
  input  arb_id_e push_id_i,
  input  logic    pop_i,
  output logic    full_o,
  output logic    empty_o,
  output arb_id_e head_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  logic [DEPTH-1:0] slot_q, slot_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pop_s;
  logic             push_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_LAST) begin
      return '0;
    end else begin
      return ptr + PTR_W'(1);
    end
  endfunction

  // Pops on an empty FIFO are ignored so the counter cannot underflow.
  assign pop_s   = pop_i & (cnt_q != '0);
  assign push_s  = push_i & ((cnt_q != CNT_FULL) | pop_s);
  assign full_o  = (cnt_q == CNT_FULL);
  assign empty_o = (cnt_q == '0);
  assign head_o  = arb_id_e'(slot_q[rd_ptr_q]);

  always_comb begin
    slot_d   = slot_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_s) begin
      slot_d[wr_ptr_q] = push_id_i;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slot_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      slot_q   <= slot_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/xmint_mem_arbiter.sv
// Shares one req/gnt/rvalid memory port between instruction fetch and data access.
// Define XMINT_ARB_RR_EN for round-robin on contention; default is fixed data priority.
module xmint_mem_arbiter
  import xmint_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    instr_req_i,
  output logic                    instr_gnt_o,
  output logic                    instr_rvalid_o,
  input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
  input  logic                    data_req_i,
  output logic                    data_gnt_o,
  output logic                    data_rvalid_o,
  input  logic                    data_we_i,
  input  logic [DATA_WIDTH/8-1:0] data_be_i,
  input  logic [ADDR_WIDTH-1:0]   data_addr_i,
  input  logic [DATA_WIDTH-1:0]   data_wdata_i,
  input  logic [6:0]              data_wdata_intg_i,
  output logic                    mem_req_o,
  input  logic                    mem_gnt_i,
  input  logic                    mem_rvalid_i,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  output logic [6:0]              mem_wdata_intg_o
);

  localparam int unsigned BE_W = DATA_WIDTH / 8;

  lock_state_e lock_state_q, lock_state_d;
  arb_id_e     lock_id_q, lock_id_d;
  arb_id_e     arb_sel_s;
  arb_id_e     sel_s;
  arb_id_e     fifo_head_s;
  logic        fifo_full_s;
  logic        fifo_empty_s;
  logic        lock_req_s;
  logic        mem_req_s;
  logic        push_s;

`ifdef XMINT_ARB_RR_EN
  arb_id_e last_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= ARB_ID_INSTR;
    end else if (push_s) begin
      last_q <= sel_s;
    end else begin
      last_q <= last_q;
    end
  end
`endif

  always_comb begin
    arb_sel_s = ARB_ID_INSTR;
    if (instr_req_i && data_req_i) begin
`ifdef XMINT_ARB_RR_EN
      arb_sel_s = (last_q == ARB_ID_DATA) ? ARB_ID_INSTR : ARB_ID_DATA;
`else
      arb_sel_s = ARB_ID_DATA;
`endif
    end else if (data_req_i) begin
      arb_sel_s = ARB_ID_DATA;
    end else begin
      arb_sel_s = ARB_ID_INSTR;
    end
  end

  // A locked requester that drops its request forfeits the lock immediately.
  assign lock_req_s = (lock_id_q == ARB_ID_DATA) ? data_req_i : instr_req_i;
  assign sel_s      = ((lock_state_q == LOCK_HELD) && lock_req_s) ? lock_id_q : arb_sel_s;

  // When full, a same-cycle response frees a slot, so the request may still issue.
  assign mem_req_s = (instr_req_i | data_req_i) & (~fifo_full_s | mem_rvalid_i) & rst_ni;
  assign push_s    = mem_req_s & mem_gnt_i;

  assign mem_req_o      = mem_req_s;
  assign instr_gnt_o    = push_s & (sel_s == ARB_ID_INSTR);
  assign data_gnt_o     = push_s & (sel_s == ARB_ID_DATA);
  assign instr_rvalid_o = mem_rvalid_i & ~fifo_empty_s & (fifo_head_s == ARB_ID_INSTR);
  assign data_rvalid_o  = mem_rvalid_i & ~fifo_empty_s & (fifo_head_s == ARB_ID_DATA);

  always_comb begin
    lock_state_d = lock_state_q;
    lock_id_d    = lock_id_q;
    case (lock_state_q)
      LOCK_IDLE: begin
        if (mem_req_s && !mem_gnt_i) begin
          lock_state_d = LOCK_HELD;
          lock_id_d    = sel_s;
        end else begin
          lock_state_d = LOCK_IDLE;
        end
      end
      LOCK_HELD: begin
        if (!lock_req_s || mem_gnt_i) begin
          lock_state_d = LOCK_IDLE;
        end else begin
          lock_state_d = LOCK_HELD;
        end
      end
      default: lock_state_d = LOCK_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_state_q <= LOCK_IDLE;
      lock_id_q    <= ARB_ID_INSTR;
    end else begin
      lock_state_q <= lock_state_d;
      lock_id_q    <= lock_id_d;
    end
  end

  always_comb begin
    mem_we_o         = 1'b0;
    mem_be_o         = '0;
    mem_addr_o       = '0;
    mem_wdata_o      = '0;
    mem_wdata_intg_o = 7'd0;
    if (mem_req_s) begin
      case (sel_s)
        ARB_ID_INSTR: begin
          mem_be_o   = ARB_BE_ALL[BE_W-1:0];
          mem_addr_o = instr_addr_i;
        end
        ARB_ID_DATA: begin
          mem_we_o         = data_we_i;
          mem_be_o         = data_be_i;
          mem_addr_o       = data_addr_i;
          mem_wdata_o      = data_wdata_i;
          mem_wdata_intg_o = data_wdata_intg_i;
        end
        default: mem_addr_o = '0;
      endcase
    end else begin
      mem_addr_o = '0;
    end
  end

  xmint_arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .push_i    (push_s),
    .push_id_i (sel_s),
    .pop_i     (mem_rvalid_i),
    .full_o    (fifo_full_s),
    .empty_o   (fifo_empty_s),
    .head_o    (fifo_head_s)
  );

endmodule

// File: tb/tb_xmint_mem_arbiter.sv
// Table-driven bench for xmint_mem_arbiter with a queue scoreboard for response routing.
module tb_xmint_mem_arbiter;

  localparam logic [31:0] IADDR = 32'h0000_0080;
  localparam logic [31:0] DADDR = 32'h0000_1000;
  localparam logic [31:0] WDATA = 32'hA5A5_0001;
  localparam logic [3:0]  DBE   = 4'h3;
  localparam logic [6:0]  DINTG = 7'h55;
  localparam logic [1:0]  SEL_N = 2'd0;
  localparam logic [1:0]  SEL_I = 2'd1;
  localparam logic [1:0]  SEL_D = 2'd2;

  logic        clk_i;
  logic        rst_ni;
  logic        instr_req_i, instr_gnt_o, instr_rvalid_o;
  logic [31:0] instr_addr_i;
  logic        data_req_i, data_gnt_o, data_rvalid_o, data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i, data_wdata_i;
  logic [6:0]  data_wdata_intg_i;
  logic        mem_req_o, mem_gnt_i, mem_rvalid_i, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [6:0]  mem_wdata_intg_o;

  typedef struct {
    logic       ireq;
    logic       dreq;
    logic       gnt;
    logic       rv;
    logic [1:0] esel;
    logic       eig;
    logic       edg;
  } vec_t;

  vec_t tbl[$];
  logic sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  xmint_mem_arbiter #(
    .ADDR_WIDTH      (32),
    .DATA_WIDTH      (32),
    .MAX_OUTSTANDING (2)
  ) dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .instr_req_i       (instr_req_i),
    .instr_gnt_o       (instr_gnt_o),
    .instr_rvalid_o    (instr_rvalid_o),
    .instr_addr_i      (instr_addr_i),
    .data_req_i        (data_req_i),
    .data_gnt_o        (data_gnt_o),
    .data_rvalid_o     (data_rvalid_o),
    .data_we_i         (data_we_i),
    .data_be_i         (data_be_i),
    .data_addr_i       (data_addr_i),
    .data_wdata_i      (data_wdata_i),
    .data_wdata_intg_i (data_wdata_intg_i),
    .mem_req_o         (mem_req_o),
    .mem_gnt_i         (mem_gnt_i),
    .mem_rvalid_i      (mem_rvalid_i),
    .mem_we_o          (mem_we_o),
    .mem_be_o          (mem_be_o),
    .mem_addr_o        (mem_addr_o),
    .mem_wdata_o       (mem_wdata_o),
    .mem_wdata_intg_o  (mem_wdata_intg_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic vec_t mk(input logic ir, input logic dr, input logic g, input logic rv,
                              input logic [1:0] es, input logic eig, input logic edg);
    vec_t v;
    v.ireq = ir; v.dreq = dr; v.gnt = g; v.rv = rv;
    v.esel = es; v.eig = eig; v.edg = edg;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drives one cycle at the falling edge, checks the combinational response 1 ns later.
  task automatic apply(input vec_t v, input string tag);
    logic        e_irv, e_drv, hid;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [39:0] e_wr;
    instr_req_i  = v.ireq;
    data_req_i   = v.dreq;
    mem_gnt_i    = v.gnt;
    mem_rvalid_i = v.rv;
    e_irv = 1'b0;
    e_drv = 1'b0;
    if (v.rv && sb.size() > 0) begin
      hid   = sb.pop_front();
      e_irv = ~hid;
      e_drv = hid;
    end
    case (v.esel)
      SEL_I:   begin e_addr = IADDR; e_be = 4'hF; e_wr = 40'd0; end
      SEL_D:   begin e_addr = DADDR; e_be = DBE;  e_wr = {1'b1, WDATA, DINTG}; end
      default: begin e_addr = 32'd0; e_be = 4'h0; e_wr = 40'd0; end
    endcase
    #1;
    chk({tag, ".ctl"},
        {59'd0, mem_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o},
        {59'd0, (v.esel != SEL_N), v.eig, v.edg, e_irv, e_drv});
    chk({tag, ".addr"}, {32'd0, mem_addr_o}, {32'd0, e_addr});
    chk({tag, ".be"}, {60'd0, mem_be_o}, {60'd0, e_be});
    chk({tag, ".wr"}, {24'd0, mem_we_o, mem_wdata_o, mem_wdata_intg_o}, {24'd0, e_wr});
    if (v.eig) sb.push_back(1'b0);
    if (v.edg) sb.push_back(1'b1);
    @(negedge clk_i);
  endtask

  initial begin
    rst_ni            = 1'b0;
    instr_req_i       = 1'b0;
    data_req_i        = 1'b0;
    mem_gnt_i         = 1'b0;
    mem_rvalid_i      = 1'b0;
    instr_addr_i      = IADDR;
    data_addr_i       = DADDR;
    data_we_i         = 1'b1;
    data_be_i         = DBE;
    data_wdata_i      = WDATA;
    data_wdata_intg_i = DINTG;

    // instr-only grant and response; contention
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, SEL_N, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, SEL_I, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, SEL_N, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, SEL_D, 1'b0, 1'b1));
`ifdef XMINT_ARB_RR_EN
    tbl.push_back(mk(1'b1, 1'b1, 1'b1, 1'b1, SEL_I, 1'b1, 1'b0));
`else
    tbl.push_back(mk(1'b1, 1'b1, 1'b1, 1'b1, SEL_D, 1'b0, 1'b1));
`endif
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, SEL_N, 1'b0, 1'b0));
    // data locked for three ungranted cycles, instr joins, then instr served
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, SEL_D, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, SEL_D, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, SEL_D, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, SEL_D, 1'b0, 1'b1));
    tbl.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, SEL_I, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, SEL_N, 1'b0, 1'b0));
    // instr locked, data arrives: lock overrides data priority
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, SEL_I, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, SEL_I, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, SEL_I, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, SEL_D, 1'b0, 1'b1));
    // full: suppressed, then same-cycle pop lets a grant through
    tbl.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, SEL_N, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, SEL_I, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, SEL_N, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, SEL_N, 1'b0, 1'b0));
    // ordering instr, data, instr
    tbl.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, SEL_I, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, SEL_D, 1'b0, 1'b1));
    tbl.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, SEL_I, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, SEL_N, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, SEL_N, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, SEL_N, 1'b0, 1'b0));
    // locked instr drops its request: lock abandoned, data granted instead
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, SEL_I, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, SEL_D, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, SEL_N, 1'b0, 1'b0));

    @(negedge clk_i);
    apply(mk(1'b1, 1'b1, 1'b1, 1'b1, SEL_N, 1'b0, 1'b0), "reset");
    rst_ni = 1'b1;

    foreach (tbl[i]) begin
      apply(tbl[i], $sformatf("v%0d", i));
    end

    // reset with two outstanding, late responses dropped, depth still exactly two
    apply(mk(1'b1, 1'b0, 1'b1, 1'b0, SEL_I, 1'b1, 1'b0), "pre_rst_i");
    apply(mk(1'b0, 1'b1, 1'b1, 1'b0, SEL_D, 1'b0, 1'b1), "pre_rst_d");
    rst_ni = 1'b0;
    sb.delete();
    apply(mk(1'b0, 1'b0, 1'b0, 1'b1, SEL_N, 1'b0, 1'b0), "in_rst");
    rst_ni = 1'b1;
    apply(mk(1'b0, 1'b0, 1'b0, 1'b1, SEL_N, 1'b0, 1'b0), "late_rv0");
    apply(mk(1'b0, 1'b0, 1'b0, 1'b1, SEL_N, 1'b0, 1'b0), "late_rv1");
    apply(mk(1'b1, 1'b0, 1'b1, 1'b0, SEL_I, 1'b1, 1'b0), "post_i");
    apply(mk(1'b0, 1'b1, 1'b1, 1'b0, SEL_D, 1'b0, 1'b1), "post_d");
    apply(mk(1'b1, 1'b0, 1'b1, 1'b0, SEL_N, 1'b0, 1'b0), "post_full");
    apply(mk(1'b0, 1'b0, 1'b0, 1'b1, SEL_N, 1'b0, 1'b0), "post_rv0");
    apply(mk(1'b0, 1'b0, 1'b0, 1'b1, SEL_N, 1'b0, 1'b0), "post_rv1");
    apply(mk(1'b0, 1'b0, 1'b0, 1'b1, SEL_N, 1'b0, 1'b0), "post_rv2");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
